// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data-memory port: loads with lane extraction, stores with RMW merge.
// Optional MAU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module mem_access_unit #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        mem_ce,
   output logic        mem_we,
   output logic        mem_rr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_w_mask,
   output logic [3:0]  mem_r_mask,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b010;
   localparam logic [2:0] OP_LW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD1,
      S_RD2,
      S_WR,
      S_RESP
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                mis;

   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W+2];

`ifdef MAU_MISALIGN_TRAP_EN
   logic err_q, err_d;

   always_comb begin
      mis = 1'b0;
      unique case (req_op)
         OP_LH, OP_LHU, OP_SH: mis = req_addr[0];
         OP_LW, OP_SW:         mis = |req_addr[1:0];
         default:              mis = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   always_comb begin
      err_d = err_q;
      if (state_q == S_IDLE && req_valid) err_d = mis;
   end
`else
   assign mis = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr[ADDR_W+1:0];
               wdata_d = req_wdata;
               if (mis)                  state_d = S_RESP;
               else if (req_op == OP_SW) state_d = S_WR;
               else                      state_d = S_RD1;
            end
         end
         S_RD1:  state_d = S_RD2;
         S_RD2: begin
            if (op_q == OP_SB || op_q == OP_SH) state_d = S_WR;
            else                                state_d = S_RESP;
         end
         S_WR:   state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v;
   logic [31:0] merged;

   always_comb begin
      byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_v = '0;
      unique case (op_q)
         OP_LB:   load_v = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_v = {24'd0, byte_v};
         OP_LH:   load_v = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_v = {16'd0, half_v};
         OP_LW:   load_v = mem_rdata;
         default: load_v = '0;
      endcase
   end

   // Memory masks only cover low lanes, so sub-word stores write a merged full word
   always_comb begin
      merged = mem_rdata;
      unique case (op_q)
         OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         OP_SH:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   assign mem_addr = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};

   always_comb begin
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_ce     = 1'b0;
      mem_we     = 1'b0;
      mem_rr     = 1'b0;
      mem_wdata  = '0;
      mem_w_mask = 4'b0000;
      mem_r_mask = 4'b0000;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         S_RD1, S_RD2: begin
            mem_ce     = 1'b1;
            mem_rr     = 1'b1;
            mem_r_mask = 4'b1111;
         end
         S_WR: begin
            mem_ce     = 1'b1;
            mem_we     = 1'b1;
            mem_w_mask = 4'b1111;
            mem_wdata  = merged;
         end
         S_RESP: begin
            resp_valid = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
            resp_err   = err_q;
            resp_rdata = err_q ? 32'd0 : load_v;
`else
            resp_rdata = load_v;
`endif
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
